sprite_dispatcher: RTL and testbench

//  Initiator side of the sprite request handshake. Queues sprite draw commands from game logic.

---
 rtl/sprite_pkg.sv | 20 ++
 rtl/sprite_cmd_fifo.sv | 79 +++++++
 rtl/sprite_dispatcher.sv | 131 +++++++++++++
 tb/tb_sprite_dispatcher.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared types and widths for the sprite dispatcher and its command FIFO.
package sprite_pkg;

   localparam int SPRITE_NUM_W = 6;
   localparam int DONE_COUNT_W = 16;

   typedef enum logic [2:0] {
      IDLE,
      REQUEST,
      RELEASE,
      WAIT_DONE,
      ACK
   } dispatcher_state_t;

   // The timer holds values 0..cycles, so it needs one more code than the limit.
   function automatic int timer_width(input int cycles);
      return $clog2(cycles + 1);
   endfunction

endpackage

// File: rtl/sprite_cmd_fifo.sv
// Command queue between game logic and the dispatcher FSM.
// Head entry is visible on rd_data while non-empty; flush drops every entry at once.
module sprite_cmd_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 6
) (
   input  logic                   Clk,
   input  logic                   Reset_n,
   input  logic                   push,
   input  logic                   pop,
   input  logic                   flush,
   input  logic [WIDTH-1:0]       wr_data,
   output logic [WIDTH-1:0]       rd_data,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]    level_q, level_d;
   logic             do_push, do_pop;

   assign full    = (level_q == LW'(DEPTH));
   assign empty   = (level_q == '0);
   assign level   = level_q;
   assign rd_data = mem_q[rd_ptr_q];

   assign do_push = push && !full && !flush;
   assign do_pop  = pop && !empty && !flush;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end else begin
         if (do_push) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
         end
         if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
         endcase
      end
   end

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Storage carries no reset; level_q alone defines which entries are valid.
   always_ff @(posedge Clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/sprite_dispatcher.sv
// Issues queued sprite draw commands one at a time over the four-phase
// incoming/received/finished/acknowledge handshake; counts completions and flags stalls.
//
//  state     | meaning
//  IDLE      | waiting for a queued command; pops it into sprite_num
//  REQUEST   | sprite_incoming high until communicator sets sprite_received
//  RELEASE   | request dropped, waiting for sprite_received to fall
//  WAIT_DONE | blit in progress, timeout timer running
//  ACK       | acknowledge high until sprite_finished falls
module sprite_dispatcher
   import sprite_pkg::*;
#(
   parameter int DEPTH          = 4,
   parameter int TIMEOUT_CYCLES = 2**20
) (
   input  logic                    Clk,
   input  logic                    Reset_n,
   input  logic                    cmd_valid,
   input  logic [SPRITE_NUM_W-1:0] cmd_sprite_num,
   output logic                    cmd_ready,
   input  logic                    flush,
   output logic                    sprite_incoming,
   output logic [SPRITE_NUM_W-1:0] sprite_num,
   input  logic                    sprite_received,
   input  logic                    sprite_finished,
   output logic                    acknowledge_finished_sprite,
   output logic                    busy,
   output logic [$clog2(DEPTH):0]  fifo_level,
   output logic [DONE_COUNT_W-1:0] done_count,
   output logic                    err_timeout,
   input  logic                    err_clear
);

   localparam int TW = timer_width(TIMEOUT_CYCLES);

   dispatcher_state_t       state_q, state_d;
   logic [SPRITE_NUM_W-1:0] sprite_num_q, sprite_num_d;
   logic [TW-1:0]           timer_q, timer_d;
   logic [DONE_COUNT_W-1:0] done_count_q, done_count_d;
   logic                    err_q, err_d;

   logic                    fifo_full, fifo_empty;
   logic [SPRITE_NUM_W-1:0] fifo_rd_data;
   logic                    push, pop;

   assign cmd_ready = !fifo_full && !flush;
   assign push      = cmd_valid && cmd_ready;
   assign pop       = (state_q == IDLE) && !fifo_empty && !flush;

   sprite_cmd_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (SPRITE_NUM_W)
   ) u_fifo (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .push    (push),
      .pop     (pop),
      .flush   (flush),
      .wr_data (cmd_sprite_num),
      .rd_data (fifo_rd_data),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .level   (fifo_level)
   );

   always_comb begin
      state_d      = state_q;
      sprite_num_d = sprite_num_q;
      timer_d      = timer_q;
      done_count_d = done_count_q;
      err_d        = err_q;
      case (state_q)
         IDLE: begin
            if (pop) begin
               sprite_num_d = fifo_rd_data;
               state_d      = REQUEST;
            end
         end
         REQUEST: begin
            if (sprite_received) state_d = RELEASE;
         end
         RELEASE: begin
            if (!sprite_received) begin
               state_d = WAIT_DONE;
               timer_d = TW'(TIMEOUT_CYCLES);
            end
         end
         WAIT_DONE: begin
            if (timer_q != '0) timer_d = timer_q - TW'(1);
            if (sprite_finished) begin
               state_d = ACK;
               timer_d = '0;
            end
         end
         ACK: begin
            if (!sprite_finished) begin
               state_d      = IDLE;
               done_count_d = done_count_q + DONE_COUNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
      // Down-counter loaded with the limit; terminal count 1 marks the last allowed cycle.
      if (err_clear) err_d = 1'b0;
      if ((state_q == WAIT_DONE) && (timer_q == TW'(1))) err_d = 1'b1;
   end

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         state_q      <= IDLE;
         sprite_num_q <= '0;
         timer_q      <= '0;
         done_count_q <= '0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         sprite_num_q <= sprite_num_d;
         timer_q      <= timer_d;
         done_count_q <= done_count_d;
         err_q        <= err_d;
      end
   end

   assign sprite_incoming             = (state_q == REQUEST);
   assign acknowledge_finished_sprite = (state_q == ACK);
   assign sprite_num                  = sprite_num_q;
   assign done_count                  = done_count_q;
   assign err_timeout                 = err_q;
   assign busy                        = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_sprite_dispatcher.sv
// Directed bench for sprite_dispatcher paired with a behavioural sprite communicator.
module tb_sprite_dispatcher;

   logic        Clk = 1'b0;
   logic        Reset_n;
   logic        cmd_valid;
   logic [5:0]  cmd_sprite_num;
   logic        cmd_ready;
   logic        flush;
   logic        sprite_incoming;
   logic [5:0]  sprite_num;
   logic        sprite_received = 1'b0;
   logic        sprite_finished = 1'b0;
   logic        acknowledge_finished_sprite;
   logic        busy;
   logic [2:0]  fifo_level;
   logic [15:0] done_count;
   logic        err_timeout;
   logic        err_clear;

   int   n_checks = 0;
   int   n_fail   = 0;
   logic hold     = 1'b0;
   int   n_cycles = 10;
   int   fin_cnt  = 0;
   logic prev_inc = 1'b0;
   logic overlap  = 1'b0;

   sprite_dispatcher #(
      .DEPTH          (4),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .Clk                         (Clk),
      .Reset_n                     (Reset_n),
      .cmd_valid                   (cmd_valid),
      .cmd_sprite_num              (cmd_sprite_num),
      .cmd_ready                   (cmd_ready),
      .flush                       (flush),
      .sprite_incoming             (sprite_incoming),
      .sprite_num                  (sprite_num),
      .sprite_received             (sprite_received),
      .sprite_finished             (sprite_finished),
      .acknowledge_finished_sprite (acknowledge_finished_sprite),
      .busy                        (busy),
      .fifo_level                  (fifo_level),
      .done_count                  (done_count),
      .err_timeout                 (err_timeout),
      .err_clear                   (err_clear)
   );

   always #5 Clk = ~Clk;

   // Communicator: received follows incoming by a cycle; finished rises n_cycles
   // after incoming drops (paused while hold) and falls once the ack is seen.
   always @(posedge Clk) begin
      #2;
      sprite_received = sprite_incoming;
      if (prev_inc && !sprite_incoming) begin
         fin_cnt = n_cycles;
      end else if (fin_cnt > 0 && !hold) begin
         fin_cnt = fin_cnt - 1;
         if (fin_cnt == 0) sprite_finished = 1'b1;
      end
      if (acknowledge_finished_sprite) sprite_finished = 1'b0;
      prev_inc = sprite_incoming;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed no end of test, expected finish before 200000");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge Clk);
      #1;
      if (sprite_incoming && acknowledge_finished_sprite) overlap = 1'b1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic sig(input int sel);
      case (sel)
         0:       return sprite_incoming;
         1:       return acknowledge_finished_sprite;
         default: return cmd_ready;
      endcase
   endfunction

   task automatic wait_until(input int sel, input logic lvl, input string tag, output int cycles);
      cycles = 0;
      while (sig(sel) !== lvl && cycles < 200) begin
         tick();
         cycles++;
      end
      chk(tag, 32'(cycles < 200), 1);
   endtask

   task automatic run_one(input logic [5:0] exp_num, input string tag);
      int c;
      wait_until(1, 1'b1, {tag, "_ack_rise"}, c);
      chk({tag, "_num"}, sprite_num, exp_num);
      wait_until(1, 1'b0, {tag, "_ack_fall"}, c);
   endtask

   initial begin
      int   c;
      logic seen_req;
      Reset_n        = 1'b0;
      cmd_valid      = 1'b0;
      cmd_sprite_num = '0;
      flush          = 1'b0;
      err_clear      = 1'b0;
      tick();
      tick();
      chk("rst_ready", cmd_ready, 1);
      chk("rst_incoming", sprite_incoming, 0);
      chk("rst_ack", acknowledge_finished_sprite, 0);
      chk("rst_busy", busy, 0);
      chk("rst_level", fifo_level, 0);
      chk("rst_done", done_count, 0);
      chk("rst_err", err_timeout, 0);
      chk("rst_num", sprite_num, 0);
      Reset_n = 1'b1;
      tick();

      // single sprite, latency from push to request
      n_cycles       = 10;
      cmd_valid      = 1'b1;
      cmd_sprite_num = 6'd5;
      tick();
      cmd_valid = 1'b0;
      chk("t1_level_push", fifo_level, 1);
      chk("t1_inc_early", sprite_incoming, 0);
      chk("t1_busy", busy, 1);
      tick();
      chk("t1_inc", sprite_incoming, 1);
      chk("t1_num", sprite_num, 5);
      chk("t1_level_pop", fifo_level, 0);
      wait_until(0, 1'b0, "t1_release", c);
      wait_until(1, 1'b1, "t1_ack_rise", c);
      chk("t1_num_ack", sprite_num, 5);
      wait_until(1, 1'b0, "t1_ack_fall", c);
      chk("t1_ack_len", 32'(c >= 1 && c <= 2), 1);
      chk("t1_done", done_count, 1);
      chk("t1_busy_end", busy, 0);

      // three back-to-back, issued in order without overlap
      overlap        = 1'b0;
      cmd_valid      = 1'b1;
      cmd_sprite_num = 6'd3;
      tick();
      cmd_sprite_num = 6'd7;
      tick();
      cmd_sprite_num = 6'd9;
      tick();
      cmd_valid = 1'b0;
      run_one(6'd3, "t2a");
      run_one(6'd7, "t2b");
      run_one(6'd9, "t2c");
      chk("t2_overlap", overlap, 0);
      chk("t2_done", done_count, 4);
      chk("t2_busy", busy, 0);

      // fill the FIFO while the first sprite is held in WAIT_DONE
      n_cycles  = 5;
      hold      = 1'b1;
      cmd_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         cmd_sprite_num = 6'(10 + i);
         tick();
      end
      chk("t3_level_full", fifo_level, 4);
      chk("t3_ready_full", cmd_ready, 0);
      chk("t3_num_first", sprite_num, 10);
      chk("t3_busy", busy, 1);
      cmd_sprite_num = 6'd15;
      tick();
      tick();
      tick();
      chk("t3_level_hold", fifo_level, 4);
      chk("t3_ready_hold", cmd_ready, 0);
      hold = 1'b0;
      wait_until(2, 1'b1, "t3_ready_back", c);
      tick();
      cmd_valid = 1'b0;
      chk("t3_level_refill", fifo_level, 4);
      for (int i = 11; i <= 15; i++) run_one(6'(i), "t3");
      chk("t3_done", done_count, 10);
      chk("t3_err", err_timeout, 0);
      chk("t3_busy_end", busy, 0);

      // timeout: set on the 16th WAIT_DONE cycle, wins over err_clear, sticky
      n_cycles       = 40;
      cmd_valid      = 1'b1;
      cmd_sprite_num = 6'd20;
      tick();
      cmd_valid = 1'b0;
      wait_until(0, 1'b1, "t4_req", c);
      wait_until(0, 1'b0, "t4_release", c);
      repeat (16) tick();
      chk("t4_err_before", err_timeout, 0);
      err_clear = 1'b1;
      tick();
      err_clear = 1'b0;
      chk("t4_err_set_wins", err_timeout, 1);
      wait_until(1, 1'b1, "t4_ack_rise", c);
      chk("t4_num", sprite_num, 20);
      wait_until(1, 1'b0, "t4_ack_fall", c);
      chk("t4_err_sticky", err_timeout, 1);
      chk("t4_done", done_count, 11);
      err_clear = 1'b1;
      tick();
      err_clear = 1'b0;
      chk("t4_err_cleared", err_timeout, 0);

      // flush with one sprite in flight and three queued
      n_cycles  = 10;
      hold      = 1'b1;
      cmd_valid = 1'b1;
      cmd_sprite_num = 6'd2;
      tick();
      cmd_sprite_num = 6'd30;
      tick();
      cmd_sprite_num = 6'd31;
      tick();
      cmd_sprite_num = 6'd32;
      tick();
      cmd_valid = 1'b0;
      tick();
      chk("t5_level", fifo_level, 3);
      chk("t5_num", sprite_num, 2);
      flush = 1'b1;
      #1;
      chk("t5_ready_flush", cmd_ready, 0);
      tick();
      flush = 1'b0;
      chk("t5_level_flushed", fifo_level, 0);
      chk("t5_busy_inflight", busy, 1);
      hold = 1'b0;
      run_one(6'd2, "t5");
      chk("t5_done", done_count, 12);
      seen_req = 1'b0;
      repeat (20) begin
         tick();
         if (sprite_incoming) seen_req = 1'b1;
      end
      chk("t5_no_more_req", seen_req, 0);
      chk("t5_busy_end", busy, 0);
      chk("t5_err", err_timeout, 0);

      // reset in the middle of a request
      cmd_valid      = 1'b1;
      cmd_sprite_num = 6'd40;
      tick();
      cmd_sprite_num = 6'd41;
      tick();
      cmd_valid = 1'b0;
      chk("t6_inc_before", sprite_incoming, 1);
      chk("t6_level_before", fifo_level, 1);
      Reset_n = 1'b0;
      tick();
      chk("t6_inc", sprite_incoming, 0);
      chk("t6_ack", acknowledge_finished_sprite, 0);
      chk("t6_level", fifo_level, 0);
      chk("t6_done", done_count, 0);
      chk("t6_busy", busy, 0);
      chk("t6_num", sprite_num, 0);
      chk("t6_ready", cmd_ready, 1);
      Reset_n = 1'b1;
      tick();
      chk("t6_idle_after", sprite_incoming, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
